// File: rtl/iir_lookahead_mc.sv
// ============================================================================
// Module      : iir_lookahead_mc
// Description : Time-multiplexed, multi-channel 2nd-order lookahead IIR filter,
//               2-cycle latency. Define IIR_LOOKAHEAD_MC_SAT_EN to saturate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_lookahead_mc #(
   parameter int W      = 9,
   parameter int COEF_W = 9,
   parameter int NCH    = 2,
   parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [W-1:0]      din,
   input  logic [CH_W-1:0]   din_ch,
   input  logic              vin,
   input  logic [COEF_W-1:0] a1,
   input  logic [COEF_W-1:0] c2,
   input  logic [COEF_W-1:0] c3,
   input  logic [COEF_W-1:0] b0,
   input  logic [COEF_W-1:0] b1,
   input  logic [COEF_W-1:0] b2,
   input  logic              coef_ld,
   input  logic              clr,
   output logic [W-1:0]      dout,
   output logic [CH_W-1:0]   dout_ch,
   output logic              vout
);

   localparam int F     = COEF_W - 1;
   localparam int ACC_W = W + COEF_W + 2;
   localparam int SUM_W = ACC_W + 1;

`ifdef IIR_LOOKAHEAD_MC_SAT_EN
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;
`endif

   function automatic logic signed [W-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef IIR_LOOKAHEAD_MC_SAT_EN
      if (v > SAT_HI)
         reduce = SAT_HI[W-1:0];
      else if (v < SAT_LO)
         reduce = SAT_LO[W-1:0];
      else
         reduce = v[W-1:0];
`else
      reduce = v[W-1:0];
`endif
   endfunction

   logic signed [COEF_W-1:0] a1_r, c2_r, c3_r, b0_r, b1_r, b2_r;

   logic                    s1_valid;
   logic signed [W-1:0]     s1_x;
   logic [CH_W-1:0]         s1_ch;

   logic signed [W-1:0]     x1_mem [NCH];
   logic signed [W-1:0]     w1_mem [NCH];
   logic signed [W-1:0]     w2_mem [NCH];
   logic signed [W-1:0]     w3_mem [NCH];

   logic                    ch_ok;
   logic signed [W-1:0]     x1_cur, w1_cur, w2_cur, w3_cur;
   logic signed [ACC_W-1:0] acc_w, acc_y;
   logic signed [W-1:0]     w_new, y_new;

   assign ch_ok = ({1'b0, din_ch} < (CH_W + 1)'(NCH));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         a1_r <= '0;
         c2_r <= '0;
         c3_r <= '0;
         b0_r <= '0;
         b1_r <= '0;
         b2_r <= '0;
      end else if (coef_ld) begin
         a1_r <= a1;
         c2_r <= c2;
         c3_r <= c3;
         b0_r <= b0;
         b1_r <= b1;
         b2_r <= b2;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_ch    <= '0;
      end else begin
         s1_valid <= vin & ch_ok & ~clr;
         if (vin && ch_ok) begin
            s1_x  <= din;
            s1_ch <= din_ch;
         end
      end
   end

   // State is written at the processing edge, so a same-channel sample one
   // cycle behind reads the updated history straight from the arrays.
   assign x1_cur = x1_mem[s1_ch];
   assign w1_cur = w1_mem[s1_ch];
   assign w2_cur = w2_mem[s1_ch];
   assign w3_cur = w3_mem[s1_ch];

   assign acc_w = ACC_W'(c2_r) * ACC_W'(w2_cur)
                + ACC_W'(c3_r) * ACC_W'(w3_cur)
                - ACC_W'(a1_r) * ACC_W'(x1_cur);
   assign w_new = reduce(SUM_W'(s1_x) + SUM_W'(acc_w >>> F));

   assign acc_y = ACC_W'(b0_r) * ACC_W'(w_new)
                + ACC_W'(b1_r) * ACC_W'(w1_cur)
                + ACC_W'(b2_r) * ACC_W'(w2_cur);
   assign y_new = reduce(SUM_W'(acc_y >>> F));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            x1_mem[i] <= '0;
            w1_mem[i] <= '0;
            w2_mem[i] <= '0;
            w3_mem[i] <= '0;
         end
         dout    <= '0;
         dout_ch <= '0;
         vout    <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < NCH; i++) begin
            x1_mem[i] <= '0;
            w1_mem[i] <= '0;
            w2_mem[i] <= '0;
            w3_mem[i] <= '0;
         end
         vout <= 1'b0;
      end else begin
         vout <= s1_valid;
         if (s1_valid) begin
            x1_mem[s1_ch] <= s1_x;
            w1_mem[s1_ch] <= w_new;
            w2_mem[s1_ch] <= w1_cur;
            w3_mem[s1_ch] <= w2_cur;
            dout          <= y_new;
            dout_ch       <= s1_ch;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iir_lookahead_mc.sv
// ============================================================================
// Module      : tb_iir_lookahead_mc
// Description : Directed self-checking bench for iir_lookahead_mc (W=9, NCH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iir_lookahead_mc;

   localparam int W      = 9;
   localparam int COEF_W = 9;
   localparam int NCH    = 2;
   localparam int CH_W   = 1;

   logic              clock = 1'b0;
   logic              rst_n;
   logic [W-1:0]      din;
   logic [CH_W-1:0]   din_ch;
   logic              vin;
   logic [COEF_W-1:0] a1, c2, c3, b0, b1, b2;
   logic              coef_ld;
   logic              clr;
   logic [W-1:0]      dout;
   logic [CH_W-1:0]   dout_ch;
   logic              vout;

   int n_checks = 0;
   int n_errors = 0;

   iir_lookahead_mc #(.W(W), .COEF_W(COEF_W), .NCH(NCH)) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .din     (din),
      .din_ch  (din_ch),
      .vin     (vin),
      .a1      (a1),
      .c2      (c2),
      .c3      (c3),
      .b0      (b0),
      .b1      (b1),
      .b2      (b2),
      .coef_ld (coef_ld),
      .clr     (clr),
      .dout    (dout),
      .dout_ch (dout_ch),
      .vout    (vout)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input int x, input int ch);
      vin    = v;
      din    = W'(x);
      din_ch = CH_W'(ch);
      step();
   endtask

   task automatic idle();
      vin = 1'b0;
      step();
   endtask

   task automatic expect_out(input string tag, input int y, input int ch);
      check_val({tag, ".vout"}, int'(vout), 1);
      check_val({tag, ".dout"}, $signed(dout), y);
      check_val({tag, ".ch"}, int'(dout_ch), ch);
   endtask

   task automatic expect_idle(input string tag);
      check_val({tag, ".vout"}, int'(vout), 0);
   endtask

   task automatic load_coef(input int ka1, input int kc2, input int kc3,
                            input int kb0, input int kb1, input int kb2);
      a1      = COEF_W'(ka1);
      c2      = COEF_W'(kc2);
      c3      = COEF_W'(kc3);
      b0      = COEF_W'(kb0);
      b1      = COEF_W'(kb1);
      b2      = COEF_W'(kb2);
      coef_ld = 1'b1;
      step();
      coef_ld = 1'b0;
   endtask

   task automatic do_clr();
      vin = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; din = '0; din_ch = '0; vin = 1'b0;
      a1 = '0; c2 = '0; c3 = '0; b0 = '0; b1 = '0; b2 = '0;
      coef_ld = 1'b0; clr = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_val("rst.vout", int'(vout), 0);
      check_val("rst.dout", $signed(dout), 0);
      check_val("rst.ch", int'(dout_ch), 0);
      step();
      rst_n = 1'b1;
      step();

      // impulse through b0 = 0.5
      load_coef(0, 0, 0, 128, 0, 0);
      drive(1, 100, 0);  expect_idle("imp.lat");
      drive(1, 0, 0);    expect_out("imp0", 50, 0);
      drive(1, 0, 0);    expect_out("imp1", 0, 0);
      idle();            expect_out("imp2", 0, 0);
      idle();            expect_idle("imp.end");

      // recursion through c2, back-to-back on one channel
      do_clr();
      load_coef(0, 64, 0, 128, 0, 0);
      drive(1, 128, 0);
      drive(1, 0, 0);    expect_out("rec0", 64, 0);
      drive(1, 0, 0);    expect_out("rec1", 0, 0);
      drive(1, 0, 0);    expect_out("rec2", 16, 0);
      idle();            expect_out("rec3", 0, 0);
      idle();            expect_idle("rec.end");

      // negative truncation toward -inf, then hold
      do_clr();
      load_coef(0, 0, 0, 128, 0, 0);
      drive(1, -1, 0);
      drive(1, -3, 0);   expect_out("neg0", -1, 0);
      idle();            expect_out("neg1", -2, 0);
      idle();            expect_idle("hold");
      check_val("hold.dout", $signed(dout), -2);

      // feedforward lookahead term -a1*x1
      do_clr();
      load_coef(-128, 0, 0, 128, 0, 0);
      drive(1, 100, 0);
      drive(1, 0, 0);    expect_out("a1.0", 50, 0);
      idle();            expect_out("a1.1", 25, 0);

      // c3 feedback and b2 tap
      do_clr();
      load_coef(0, 0, 64, 128, 0, 64);
      drive(1, 128, 0);
      drive(1, 0, 0);    expect_out("c3.0", 64, 0);
      drive(1, 0, 0);    expect_out("c3.1", 0, 0);
      drive(1, 0, 0);    expect_out("c3.2", 32, 0);
      idle();            expect_out("c3.3", 16, 0);

      // channel isolation, interleaved
      do_clr();
      load_coef(0, 64, 0, 128, 0, 0);
      drive(1, 128, 0);
      drive(1, 0, 1);    expect_out("iso0", 64, 0);
      drive(1, 0, 0);    expect_out("iso1", 0, 1);
      drive(1, 0, 1);    expect_out("iso2", 0, 0);
      drive(1, 0, 0);    expect_out("iso3", 0, 1);
      drive(1, 0, 1);    expect_out("iso4", 16, 0);
      idle();            expect_out("iso5", 0, 1);

      // overflow of the output reduction
      do_clr();
      load_coef(0, 0, 0, 255, 255, 0);
      drive(1, 255, 0);
      drive(1, 255, 0);  expect_out("ovf0", 254, 0);
`ifdef IIR_LOOKAHEAD_MC_SAT_EN
      idle();            expect_out("ovf1", 255, 0);
`else
      idle();            expect_out("ovf1", -4, 0);
`endif

      // coefficient load mid-stream
      do_clr();
      load_coef(0, 0, 0, 128, 0, 0);
      drive(1, 100, 0);
      b0 = COEF_W'(64);
      coef_ld = 1'b1;
      drive(1, 100, 0);  expect_out("cld0", 50, 0);
      coef_ld = 1'b0;
      idle();            expect_out("cld1", 25, 0);

      // clear mid-stream drops the concurrent sample and the history
      do_clr();
      load_coef(0, 64, 0, 128, 0, 0);
      drive(1, 128, 0);
      drive(1, 0, 0);    expect_out("clr0", 64, 0);
      idle();            expect_out("clr1", 0, 0);
      clr = 1'b1;
      drive(1, 50, 0);   expect_idle("clr.edge");
      clr = 1'b0;
      drive(1, 0, 0);    expect_idle("clr.drop");
      idle();            expect_out("clr2", 0, 0);

      // async reset mid-stream
      do_clr();
      load_coef(0, 0, 0, 128, 0, 0);
      drive(1, 100, 0);
      vin = 1'b1; din = W'(100);
      step();            expect_out("pre.rst", 50, 0);
      vin = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("arst.vout", int'(vout), 0);
      check_val("arst.dout", $signed(dout), 0);
      step();
      rst_n = 1'b1;
      step();            expect_idle("arst.flush");
      drive(1, 100, 0);
      idle();            expect_out("arst.coef", 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
